// File: rtl/hdmi_out_pkg.sv
// Shared definitions for the HDMI output path: DDR read arbiter state
// encodings, default burst/arbitration/timeout settings and a counter-width helper.
package hdmi_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    localparam logic [31:0] DEF_BURST_BYTES  = 32'h100;
    localparam int          DEF_STARVE_LIMIT = 4;
    localparam int          DEF_TIMEOUT_CYC  = 1024;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr_read_arbiter_if.sv
// IPIF master read command/status bundle between the arbiter (master side)
// and the DDR bus master block (slave side).
interface ddr_read_arbiter_if;

    logic        IP2Bus_MstRd_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [31:0] IP2Bus_Mst_Length;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;

    modport master (
        output IP2Bus_MstRd_Req,
        output IP2Bus_Mst_Addr,
        output IP2Bus_Mst_Length,
        input  Bus2IP_Mst_CmdAck,
        input  Bus2IP_Mst_Cmplt,
        input  Bus2IP_Mst_Error
    );

    modport slave (
        input  IP2Bus_MstRd_Req,
        input  IP2Bus_Mst_Addr,
        input  IP2Bus_Mst_Length,
        output Bus2IP_Mst_CmdAck,
        output Bus2IP_Mst_Cmplt,
        output Bus2IP_Mst_Error
    );

endinterface

// File: rtl/ddr_rd_timeout.sv
// Command watchdog: cleared on load, counts while run is high, flags expire
// during the TIMEOUT_CYC-th running cycle after the load.
module ddr_rd_timeout
    import hdmi_out_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Resetn,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int            CW   = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (run && !expire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/ddr_read_arbiter.sv
// Two-client DDR read arbiter: video line fetches (pulse, one-deep pending slot)
// and an auxiliary reader (level request), video-first with a starvation guard.
module ddr_read_arbiter
    import hdmi_out_pkg::*;
#(
    parameter logic [31:0] BURST_BYTES  = DEF_BURST_BYTES,
    parameter int          STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int          TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Resetn,
    input  logic                      vid_go,
    input  logic [31:0]               vid_addr,
    input  logic                      aux_req,
    input  logic [31:0]               aux_addr,
    ddr_read_arbiter_if.master        mst,
    output logic                      vid_grant,
    output logic                      aux_grant,
    output logic                      vid_done,
    output logic                      aux_done,
    output logic                      err_flag
);

    localparam int            SW         = cnt_width(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    rd_state_t     state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          vgrant_q, vgrant_d;
    logic          agrant_q, agrant_d;
    logic          vdone_q, vdone_d;
    logic          adone_q, adone_d;
    logic          vid_pend_q, vid_pend_d;
    logic [31:0]   vid_slot_q, vid_slot_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic busy, issue, aux_wins, tmo_expire;
    logic vid_clear, bus_err, tmo_err, overrun;

    assign busy     = (state_q == ST_CMD) || (state_q == ST_XFER);
    assign aux_wins = aux_req && (!vid_pend_q || (starve_q == STARVE_MAX));
    assign issue    = (state_q == ST_IDLE) && (vid_pend_q || aux_req);

    ddr_rd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .Bus2IP_Clk   (Bus2IP_Clk),
        .Bus2IP_Resetn(Bus2IP_Resetn),
        .load         (issue),
        .run          (busy),
        .expire       (tmo_expire)
    );

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            vgrant_q   <= 1'b0;
            agrant_q   <= 1'b0;
            vdone_q    <= 1'b0;
            adone_q    <= 1'b0;
            vid_pend_q <= 1'b0;
            vid_slot_q <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            vgrant_q   <= vgrant_d;
            agrant_q   <= agrant_d;
            vdone_q    <= vdone_d;
            adone_q    <= adone_d;
            vid_pend_q <= vid_pend_d;
            vid_slot_q <= vid_slot_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        vgrant_d  = vgrant_q;
        agrant_d  = agrant_q;
        vdone_d   = 1'b0;
        adone_d   = 1'b0;
        vid_clear = 1'b0;
        bus_err   = 1'b0;
        tmo_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_CMD;
                    req_d   = 1'b1;
                    if (aux_wins) begin
                        addr_d   = aux_addr;
                        agrant_d = 1'b1;
                    end else begin
                        addr_d   = vid_slot_q;
                        vgrant_d = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (mst.Bus2IP_Mst_CmdAck) begin
                    state_d   = ST_XFER;
                    req_d     = 1'b0;
                    vid_clear = vgrant_q;
                end else if (tmo_expire) begin
                    // An abandoned video command consumes the slot so it is not reissued forever.
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    vdone_d   = vgrant_q;
                    adone_d   = agrant_q;
                    vid_clear = vgrant_q;
                    tmo_err   = 1'b1;
                end
            end
            ST_XFER: begin
                if (mst.Bus2IP_Mst_Cmplt) begin
                    state_d = ST_DONE;
                    vdone_d = vgrant_q;
                    adone_d = agrant_q;
                    bus_err = mst.Bus2IP_Mst_Error;
                end else if (tmo_expire) begin
                    state_d = ST_DONE;
                    vdone_d = vgrant_q;
                    adone_d = agrant_q;
                    tmo_err = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                vgrant_d = 1'b0;
                agrant_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vid_pend_d = vid_pend_q && !vid_clear;
        vid_slot_d = vid_slot_q;
        overrun    = 1'b0;
        // A new fetch landing on the cycle the slot is consumed is a fresh request, not an overrun.
        if (vid_go) begin
            vid_pend_d = 1'b1;
            vid_slot_d = vid_addr;
            overrun    = vid_pend_q && !vid_clear;
        end

        starve_d = starve_q;
        if (!aux_req) begin
            starve_d = '0;
        end else if (issue && aux_wins) begin
            starve_d = '0;
        end else if (issue && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        err_d = err_q || overrun || bus_err || tmo_err;
    end

    assign mst.IP2Bus_MstRd_Req  = req_q;
    assign mst.IP2Bus_Mst_Addr   = addr_q;
    assign mst.IP2Bus_Mst_Length = BURST_BYTES;
    assign vid_grant             = vgrant_q;
    assign aux_grant             = agrant_q;
    assign vid_done              = vdone_q;
    assign aux_done              = adone_q;
    assign err_flag              = err_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter with a 16-cycle command timeout.
module tb_ddr_read_arbiter;

    logic        clk;
    logic        resetn;
    logic        vid_go;
    logic [31:0] vid_addr;
    logic        aux_req;
    logic [31:0] aux_addr;
    logic        vid_grant, aux_grant, vid_done, aux_done, err_flag;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_read_arbiter_if bus ();

    ddr_read_arbiter #(
        .BURST_BYTES (32'h100),
        .STARVE_LIMIT(4),
        .TIMEOUT_CYC (16)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(resetn),
        .vid_go       (vid_go),
        .vid_addr     (vid_addr),
        .aux_req      (aux_req),
        .aux_addr     (aux_addr),
        .mst          (bus.master),
        .vid_grant    (vid_grant),
        .aux_grant    (aux_grant),
        .vid_done     (vid_done),
        .aux_done     (aux_done),
        .err_flag     (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.IP2Bus_MstRd_Req && n < 30);
        chk(tag, 32'(bus.IP2Bus_MstRd_Req), 32'd1);
    endtask

    // Called in the first Req cycle; returns in the DONE cycle.
    task automatic serve(input int ack_wait, input int cmplt_wait, input logic berr,
                         input logic vgo, input logic [31:0] vaddr);
        repeat (ack_wait) tick();
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        tick();
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        for (int k = 0; k < cmplt_wait; k++) begin
            if (vgo && k == 0) begin
                vid_go   = 1'b1;
                vid_addr = vaddr;
            end
            tick();
            vid_go = 1'b0;
        end
        bus.Bus2IP_Mst_Cmplt = 1'b1;
        bus.Bus2IP_Mst_Error = berr;
        tick();
        bus.Bus2IP_Mst_Cmplt = 1'b0;
        bus.Bus2IP_Mst_Error = 1'b0;
    endtask

    task automatic do_reset();
        resetn                = 1'b0;
        vid_go                = 1'b0;
        aux_req               = 1'b0;
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        bus.Bus2IP_Mst_Cmplt  = 1'b0;
        bus.Bus2IP_Mst_Error  = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int nd;
        int nr;
        resetn                = 1'b0;
        vid_go                = 1'b0;
        vid_addr              = '0;
        aux_req               = 1'b0;
        aux_addr              = '0;
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        bus.Bus2IP_Mst_Cmplt  = 1'b0;
        bus.Bus2IP_Mst_Error  = 1'b0;
        repeat (3) tick();

        chk("rst_req",    32'(bus.IP2Bus_MstRd_Req), 32'd0);
        chk("rst_addr",   bus.IP2Bus_Mst_Addr,       32'd0);
        chk("rst_len",    bus.IP2Bus_Mst_Length,     32'h100);
        chk("rst_grants", {30'd0, vid_grant, aux_grant}, 32'd0);
        chk("rst_dones",  {30'd0, vid_done, aux_done},   32'd0);
        chk("rst_err",    32'(err_flag), 32'd0);
        resetn = 1'b1;
        tick();

        // Single video burst, CmdAck in the second Req cycle, Cmplt 8 cycles later.
        vid_addr = 32'h1000_0000;
        vid_go   = 1'b1;
        tick();
        vid_go = 1'b0;
        chk("t1_req_pre",  32'(bus.IP2Bus_MstRd_Req), 32'd0);
        tick();
        chk("t1_req_on",   32'(bus.IP2Bus_MstRd_Req), 32'd1);
        chk("t1_addr",     bus.IP2Bus_Mst_Addr,       32'h1000_0000);
        chk("t1_len",      bus.IP2Bus_Mst_Length,     32'h100);
        chk("t1_grant",    {30'd0, vid_grant, aux_grant}, 32'd2);
        tick();
        chk("t1_req_hold", 32'(bus.IP2Bus_MstRd_Req), 32'd1);
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        tick();
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        chk("t1_req_drop", 32'(bus.IP2Bus_MstRd_Req), 32'd0);
        repeat (7) tick();
        chk("t1_xfer_grant", 32'(vid_grant), 32'd1);
        bus.Bus2IP_Mst_Cmplt = 1'b1;
        tick();
        bus.Bus2IP_Mst_Cmplt = 1'b0;
        chk("t1_vdone",      32'(vid_done),  32'd1);
        chk("t1_done_grant", 32'(vid_grant), 32'd1);
        tick();
        chk("t1_vdone_end",  32'(vid_done),  32'd0);
        chk("t1_grant_end",  {30'd0, vid_grant, aux_grant}, 32'd0);
        chk("t1_err",        32'(err_flag),  32'd0);

        // Starvation guard: aux waits through four video grants, wins the fifth.
        vid_addr = 32'h1100_0100;
        vid_go   = 1'b1;
        tick();
        vid_go   = 1'b0;
        aux_req  = 1'b1;
        aux_addr = 32'h2000_0000;
        wait_req("st_req1");
        chk("st_grant1", {30'd0, vid_grant, aux_grant}, 32'd2);
        for (int t = 1; t <= 4; t++) begin
            serve(0, 2, 1'b0, 1'b1, 32'h1100_0000 + 32'((t + 1) * 32'h100));
            chk("st_vdone", 32'(vid_done), 32'd1);
            tick();
            wait_req("st_req");
            if (t < 4) begin
                chk("st_vgrant", {30'd0, vid_grant, aux_grant}, 32'd2);
                chk("st_vaddr",  bus.IP2Bus_Mst_Addr, 32'h1100_0000 + 32'((t + 1) * 32'h100));
            end else begin
                chk("st_agrant5", {30'd0, vid_grant, aux_grant}, 32'd1);
                chk("st_aaddr5",  bus.IP2Bus_Mst_Addr, 32'h2000_0000);
            end
        end
        serve(0, 2, 1'b0, 1'b0, 32'd0);
        chk("st_adone", {30'd0, vid_done, aux_done}, 32'd1);
        aux_req = 1'b0;
        tick();
        wait_req("st_req6");
        chk("st_vgrant6", {30'd0, vid_grant, aux_grant}, 32'd2);
        chk("st_vaddr6",  bus.IP2Bus_Mst_Addr, 32'h1100_0500);
        serve(0, 1, 1'b0, 1'b0, 32'd0);
        chk("st_vdone6",  32'(vid_done), 32'd1);
        chk("st_err",     32'(err_flag), 32'd0);
        tick();

        // Video overrun while aux owns the bus: second address wins, one done.
        do_reset();
        aux_req  = 1'b1;
        aux_addr = 32'h2222_0000;
        wait_req("ov_areq");
        chk("ov_agrant", {30'd0, vid_grant, aux_grant}, 32'd1);
        vid_go   = 1'b1;
        vid_addr = 32'h3000_0000;
        tick();
        chk("ov_err_first", 32'(err_flag), 32'd0);
        vid_addr = 32'h3000_0100;
        tick();
        vid_go = 1'b0;
        chk("ov_err", 32'(err_flag), 32'd1);
        serve(0, 2, 1'b0, 1'b0, 32'd0);
        chk("ov_adone", 32'(aux_done), 32'd1);
        aux_req = 1'b0;
        tick();
        wait_req("ov_vreq");
        chk("ov_vgrant", {30'd0, vid_grant, aux_grant}, 32'd2);
        chk("ov_vaddr",  bus.IP2Bus_Mst_Addr, 32'h3000_0100);
        serve(0, 2, 1'b0, 1'b0, 32'd0);
        nd = 0;
        nr = 0;
        for (int k = 0; k < 12; k++) begin
            if (vid_done) nd++;
            if (bus.IP2Bus_MstRd_Req) nr++;
            tick();
        end
        chk("ov_vdone_cnt", 32'(nd), 32'd1);
        chk("ov_no_reissue", 32'(nr), 32'd0);

        // Reset clears the sticky error; then CmdAck never returns.
        do_reset();
        chk("rst_err_clear", 32'(err_flag), 32'd0);
        vid_addr = 32'h4000_0000;
        vid_go   = 1'b1;
        tick();
        vid_go = 1'b0;
        wait_req("to_req");
        n = 1;
        while (bus.IP2Bus_MstRd_Req && n < 40) begin
            tick();
            if (bus.IP2Bus_MstRd_Req) n++;
        end
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_req_off",    32'(bus.IP2Bus_MstRd_Req), 32'd0);
        chk("to_vdone",      32'(vid_done), 32'd1);
        chk("to_err",        32'(err_flag), 32'd1);
        tick();
        chk("to_idle_grant", {30'd0, vid_grant, aux_grant}, 32'd0);
        nr = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.IP2Bus_MstRd_Req) nr++;
        end
        chk("to_no_reissue", 32'(nr), 32'd0);

        // Completion carrying a bus error.
        do_reset();
        vid_addr = 32'h4400_0000;
        vid_go   = 1'b1;
        tick();
        vid_go = 1'b0;
        wait_req("be_req");
        serve(1, 3, 1'b1, 1'b0, 32'd0);
        chk("be_vdone", 32'(vid_done), 32'd1);
        chk("be_err",   32'(err_flag), 32'd1);
        tick();
        chk("be_grant_end", 32'(vid_grant), 32'd0);

        // Asynchronous reset in the middle of a transfer, then normal service.
        vid_addr = 32'h6000_0000;
        vid_go   = 1'b1;
        tick();
        vid_go = 1'b0;
        wait_req("ar_req");
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        tick();
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        chk("ar_xfer_grant", 32'(vid_grant), 32'd1);
        chk("ar_err_before", 32'(err_flag),  32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_req",   32'(bus.IP2Bus_MstRd_Req), 32'd0);
        chk("ar_addr",  bus.IP2Bus_Mst_Addr,       32'd0);
        chk("ar_len",   bus.IP2Bus_Mst_Length,     32'h100);
        chk("ar_grant", {30'd0, vid_grant, aux_grant}, 32'd0);
        chk("ar_err",   32'(err_flag), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        vid_addr = 32'h7000_0000;
        vid_go   = 1'b1;
        tick();
        vid_go = 1'b0;
        wait_req("ar_new_req");
        chk("ar_new_addr",  bus.IP2Bus_Mst_Addr, 32'h7000_0000);
        chk("ar_new_grant", {30'd0, vid_grant, aux_grant}, 32'd2);
        serve(0, 2, 1'b0, 1'b0, 32'd0);
        chk("ar_new_vdone", 32'(vid_done), 32'd1);
        chk("ar_new_err",   32'(err_flag), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_read_arbiter.md
DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 SHALL have parameter BURST_BYTES, default 32'h100, byte length of every read burst issued.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max consecutive video grants while aux waits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, cycles allowed from command issue to completion.
REQ-004 Bus2IP_Clk  in  1  sole clock, all logic on rising edge.
REQ-005 Bus2IP_Resetn  in  1  asynchronous, active-low reset.
REQ-006 vid_go  in  1  one-cycle fill pulse from video line-fetch FSM.
REQ-007 vid_addr  in  32  DDR byte address, sampled when vid_go=1.
REQ-008 aux_req  in  1  level request from auxiliary reader, held until aux_done.
REQ-009 aux_addr  in  32  DDR byte address, stable while aux_req=1.
REQ-010 IP2Bus_MstRd_Req  out  1  master read command request.
REQ-011 IP2Bus_Mst_Addr  out  32  command address.
REQ-012 IP2Bus_Mst_Length  out  32  command length, always BURST_BYTES.
REQ-013 Bus2IP_Mst_CmdAck  in  1  command accepted.
REQ-014 Bus2IP_Mst_Cmplt  in  1  burst complete.
REQ-015 Bus2IP_Mst_Error  in  1  burst error, valid with Cmplt.
REQ-016 vid_grant, aux_grant  out  1 each  owner of current transfer (route read data to owner's FIFO write).
REQ-017 vid_done, aux_done  out  1 each  one-cycle completion pulse to owner.
REQ-018 err_flag  out  1  sticky: bus error, timeout or video overrun.

Function
REQ-019 vid_go SHALL latch vid_addr into a one-deep pending slot and set vid_pend.
REQ-020 vid_go while vid_pend=1 SHALL overwrite the slot address and set err_flag (overrun).
REQ-021 States SHALL be IDLE, CMD, XFER, DONE.
REQ-022 IDLE: if vid_pend or aux_req, SHALL select owner, drive IP2Bus_MstRd_Req=1, address, grant, go to CMD next cycle.
REQ-023 Selection SHALL be video-first, except aux SHALL win when aux_req=1 and starve counter equals STARVE_LIMIT.
REQ-024 Starve counter SHALL increment on each video grant while aux_req=1, clear on aux grant or aux_req=0, saturate at STARVE_LIMIT.
REQ-025 CMD: hold Req, Addr, Length stable until Bus2IP_Mst_CmdAck; on CmdAck, deassert Req same edge, clear vid_pend if video owner, go to XFER.
REQ-026 vid_go arriving the same cycle vid_pend clears SHALL re-set vid_pend (new request wins).
REQ-027 XFER: on Bus2IP_Mst_Cmplt go to DONE; if Bus2IP_Mst_Error also 1, set err_flag.
REQ-028 Timeout counter SHALL run in CMD and XFER; reaching TIMEOUT_CYC SHALL set err_flag, drop Req, go to DONE.
REQ-029 DONE: one cycle, pulse owner's done, deassert grant, return to IDLE; minimum 4 cycles between two command issues.
REQ-030 Grant SHALL never change between CMD entry and DONE exit; exactly one grant high outside IDLE.
REQ-031 Length SHALL equal BURST_BYTES regardless of owner; addresses passed unmodified (no alignment correction).

Reset
REQ-032 Resetn=0 SHALL force IDLE and all outputs 0 (Mst_Length = BURST_BYTES), clear vid_pend, starve and timeout counters, err_flag, immediately, including mid-transfer.
REQ-033 err_flag SHALL clear only by reset.

Structure
REQ-034 State encodings and default BURST_BYTES/STARVE_LIMIT/TIMEOUT_CYC SHALL live in shared package hdmi_out_pkg.
REQ-035 One sub-module natural: ddr_rd_timeout (load/count/expire counter); rest flat.

Verification
REQ-036 vid_go addr 0x1000_0000, CmdAck at +2, Cmplt at +10 -> Req 2 cycles, Addr 0x1000_0000, Length 0x100, vid_done one cycle after Cmplt.
REQ-037 aux_req held with vid_go every transfer -> aux_grant on 5th transfer (after 4 video grants).
REQ-038 vid_go twice without CmdAck -> err_flag=1, second address issued, single vid_done.
REQ-039 CmdAck never returns, TIMEOUT_CYC=16 -> Req drops at cycle 16, err_flag=1, done pulse, IDLE.
REQ-040 Cmplt with Error=1 -> err_flag=1, done still pulses.
REQ-041 Resetn low during XFER -> all outputs 0 asynchronously; after release, new vid_go served normally.
